// File: rtl/alarm_arbiter_4ch_pkg.sv
// alarm_pkg: shared FSM state encodings, room count and select width for the
// four-room alarm arbiter, plus a one-hot decode helper.
package alarm_pkg;

   localparam int unsigned NUM_ROOMS = 4;
   localparam int unsigned SEL_W     = 2;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SERVE = 2'd1,
      ST_GAP   = 2'd2
   } state_t;

   // One-hot decode of a room index.
   function automatic logic [NUM_ROOMS-1:0] onehot_room(input logic [SEL_W-1:0] idx);
      logic [NUM_ROOMS-1:0] v;
      v      = '0;
      v[idx] = 1'b1;
      return v;
   endfunction

endpackage

// File: rtl/alarm_arbiter_4ch_rr_pick4.sv
// rr_pick4: combinational round-robin picker. Returns the first set bit of
// pending, searching upward from last+1 with wrap-around; any flags a hit.
module rr_pick4
   import alarm_pkg::*;
(
   input  logic [NUM_ROOMS-1:0] pending,
   input  logic [SEL_W-1:0]     last,
   output logic [SEL_W-1:0]     idx,
   output logic                 any
);

   logic [SEL_W-1:0] w_cand;
   logic             w_found;

   // Walk the four rooms starting after the last grant; first hit wins.
   always_comb begin
      idx     = '0;
      w_found = 1'b0;
      w_cand  = last;
      for (int unsigned k = 0; k < NUM_ROOMS; k++) begin
         w_cand = w_cand + 2'd1;
         if (!w_found && pending[w_cand]) begin
            idx     = w_cand;
            w_found = 1'b1;
         end
      end
      any = |pending;
   end

endmodule

// File: rtl/alarm_arbiter_4ch.sv
// alarm_arbiter_4ch: round-robin scheduler for the shared 4:1 alarm-code mux.
// Grants one room at a time, holds the grant until a nurse ack, escalates after
// ESC_TICKS unacknowledged ticks and inserts GAP_TICKS blank ticks between alarms.
// Build macro ALARM_LATCH_EN: when defined, request rising edges are latched
// into pending until acked; when undefined, pending simply follows req.
module alarm_arbiter_4ch
   import alarm_pkg::*;
#(
   parameter int unsigned ESC_TICKS = 8,
   parameter int unsigned GAP_TICKS = 2
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic [NUM_ROOMS-1:0] req,
   input  logic                 ack,
   input  logic                 tick,
   output logic [SEL_W-1:0]     sel,
   output logic [NUM_ROOMS-1:0] grant,
   output logic                 active,
   output logic                 escalate
);

   localparam int unsigned EW      = $clog2(ESC_TICKS + 1);
   localparam int unsigned GW      = (GAP_TICKS > 0) ? $clog2(GAP_TICKS + 1) : 1;
   localparam logic [EW-1:0] ESC_MAX = EW'(ESC_TICKS);
   localparam logic [GW-1:0] GAP_MAX = GW'(GAP_TICKS);

   state_t               r_state,   w_state_nxt;
   logic [SEL_W-1:0]     r_sel,     w_sel_nxt;
   logic [SEL_W-1:0]     r_last,    w_last_nxt;
   logic [NUM_ROOMS-1:0] r_grant,   w_grant_nxt;
   logic                 r_active,  w_active_nxt;
   logic                 r_esc,     w_esc_nxt;
   logic [EW-1:0]        r_esc_cnt, w_esc_cnt_nxt;
   logic [GW-1:0]        r_gap_cnt, w_gap_cnt_nxt;
   logic [NUM_ROOMS-1:0] r_pending;
   logic [SEL_W-1:0]     w_pick_idx;
   logic                 w_pick_any;
   logic                 w_withdraw;

   rr_pick4 u_pick (
      .pending (r_pending),
      .last    (r_last),
      .idx     (w_pick_idx),
      .any     (w_pick_any)
   );

`ifdef ALARM_LATCH_EN
   logic [NUM_ROOMS-1:0] r_req_d;
   logic [NUM_ROOMS-1:0] w_req_rise;
   logic [NUM_ROOMS-1:0] w_clr_mask;

   assign w_req_rise = req & ~r_req_d;
   assign w_clr_mask = (r_state == ST_SERVE && ack) ? onehot_room(r_sel) : '0;
   // A latched alarm never goes away on its own, so there is nothing to withdraw.
   assign w_withdraw = 1'b0;

   // Latch request rising edges; ack of the served room clears, a new edge wins.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_req_d   <= '0;
         r_pending <= '0;
      end else begin
         r_req_d   <= req;
         r_pending <= (r_pending & ~w_clr_mask) | w_req_rise;
      end
   end
`else
   assign w_withdraw = ~r_pending[r_sel];

   // Pending mirrors req; an ack clear would be overridden by a still-high req
   // anyway, so no explicit clear path is needed here.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_pending <= '0;
      end else begin
         r_pending <= req;
      end
   end
`endif

   // State and registered outputs.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state   <= ST_IDLE;
         r_sel     <= '0;
         r_last    <= '1;
         r_grant   <= '0;
         r_active  <= 1'b0;
         r_esc     <= 1'b0;
         r_esc_cnt <= '0;
         r_gap_cnt <= '0;
      end else begin
         r_state   <= w_state_nxt;
         r_sel     <= w_sel_nxt;
         r_last    <= w_last_nxt;
         r_grant   <= w_grant_nxt;
         r_active  <= w_active_nxt;
         r_esc     <= w_esc_nxt;
         r_esc_cnt <= w_esc_cnt_nxt;
         r_gap_cnt <= w_gap_cnt_nxt;
      end
   end

   // Next-state and next-output logic; ack beats withdrawal beats tick in SERVE.
   always_comb begin
      w_state_nxt   = r_state;
      w_sel_nxt     = r_sel;
      w_last_nxt    = r_last;
      w_grant_nxt   = r_grant;
      w_active_nxt  = r_active;
      w_esc_nxt     = r_esc;
      w_esc_cnt_nxt = r_esc_cnt;
      w_gap_cnt_nxt = r_gap_cnt;

      case (r_state)
         ST_IDLE: begin
            if (w_pick_any) begin
               w_state_nxt   = ST_SERVE;
               w_sel_nxt     = w_pick_idx;
               w_last_nxt    = w_pick_idx;
               w_grant_nxt   = onehot_room(w_pick_idx);
               w_active_nxt  = 1'b1;
               w_esc_nxt     = 1'b0;
               w_esc_cnt_nxt = '0;
            end
         end

         ST_SERVE: begin
            if (ack) begin
               w_grant_nxt   = '0;
               w_active_nxt  = 1'b0;
               w_esc_nxt     = 1'b0;
               w_esc_cnt_nxt = '0;
               w_gap_cnt_nxt = '0;
               if (GAP_TICKS == 0) begin
                  w_state_nxt = ST_IDLE;
               end else begin
                  w_state_nxt = ST_GAP;
               end
            end else if (w_withdraw) begin
               w_state_nxt   = ST_IDLE;
               w_grant_nxt   = '0;
               w_active_nxt  = 1'b0;
               w_esc_nxt     = 1'b0;
               w_esc_cnt_nxt = '0;
            end else if (tick && (r_esc_cnt != ESC_MAX)) begin
               w_esc_cnt_nxt = r_esc_cnt + EW'(1);
               if (w_esc_cnt_nxt == ESC_MAX) begin
                  w_esc_nxt = 1'b1;
               end
            end
         end

         ST_GAP: begin
            if (tick) begin
               w_gap_cnt_nxt = r_gap_cnt + GW'(1);
               if (w_gap_cnt_nxt == GAP_MAX) begin
                  w_state_nxt   = ST_IDLE;
                  w_gap_cnt_nxt = '0;
               end
            end
         end

         default: begin
            w_state_nxt  = ST_IDLE;
            w_grant_nxt  = '0;
            w_active_nxt = 1'b0;
            w_esc_nxt    = 1'b0;
         end
      endcase
   end

   assign sel      = r_sel;
   assign grant    = r_grant;
   assign active   = r_active;
   assign escalate = r_esc;

endmodule

// File: tb/tb_alarm_arbiter_4ch.sv
// tb_alarm_arbiter_4ch: directed and random checks of alarm_arbiter_4ch.
// Two instances share the stimulus: one with GAP_TICKS=2, one with GAP_TICKS=0.
// Honours ALARM_LATCH_EN in its reference model.
module tb_alarm_arbiter_4ch;

   localparam int ESC_P = 8;

   logic             clk = 1'b0;
   logic             reset_n;
   logic [3:0]       req;
   logic             ack;
   logic             tick;
   logic [1:0][1:0]  sel_o;
   logic [1:0][3:0]  grant_o;
   logic [1:0]       active_o;
   logic [1:0]       esc_o;

   int    n_tests = 0;
   int    n_fail  = 0;
   string phase   = "init";

   // Reference model state, one set per instance.
   int         m_serving [2];
   int         m_ticks   [2];
   bit         m_esc     [2];
   bit         m_in_gap  [2];
   int         m_gapcnt  [2];
   int         m_sel     [2];
   int         m_last    [2];
   logic [3:0] m_pend    [2];
   logic [3:0] m_reqd    [2];

   always #5 clk = ~clk;

   alarm_arbiter_4ch #(.ESC_TICKS(8), .GAP_TICKS(2)) u_dut_gap (
      .clk      (clk),
      .reset_n  (reset_n),
      .req      (req),
      .ack      (ack),
      .tick     (tick),
      .sel      (sel_o[0]),
      .grant    (grant_o[0]),
      .active   (active_o[0]),
      .escalate (esc_o[0])
   );

   alarm_arbiter_4ch #(.ESC_TICKS(8), .GAP_TICKS(0)) u_dut_nogap (
      .clk      (clk),
      .reset_n  (reset_n),
      .req      (req),
      .ack      (ack),
      .tick     (tick),
      .sel      (sel_o[1]),
      .grant    (grant_o[1]),
      .active   (active_o[1]),
      .escalate (esc_o[1])
   );

   function automatic int gap_of(input int d);
      return (d == 0) ? 2 : 0;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s/%s: observed=%0h expected=%0h", phase, tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int d = 0; d < 2; d++) begin
         m_serving[d] = -1;
         m_ticks[d]   = 0;
         m_esc[d]     = 1'b0;
         m_in_gap[d]  = 1'b0;
         m_gapcnt[d]  = 0;
         m_sel[d]     = 0;
         m_last[d]    = 3;
         m_pend[d]    = 4'b0000;
         m_reqd[d]    = 4'b0000;
      end
   endtask

   // One clock edge of behaviour, using the inputs sampled at that edge.
   task automatic model_edge(input logic [3:0] r, input logic a, input logic t);
      for (int d = 0; d < 2; d++) begin
         logic [3:0] old_pend;
         bit         found;
`ifdef ALARM_LATCH_EN
         logic [3:0] clr;
         clr = 4'b0000;
`endif
         old_pend = m_pend[d];
         found    = 1'b0;
         if (m_serving[d] >= 0) begin
            if (a) begin
`ifdef ALARM_LATCH_EN
               clr = 4'b0001 << m_serving[d];
`endif
               m_serving[d] = -1;
               m_ticks[d]   = 0;
               m_esc[d]     = 1'b0;
               if (gap_of(d) > 0) begin
                  m_in_gap[d] = 1'b1;
                  m_gapcnt[d] = 0;
               end
            end else if (!old_pend[m_serving[d]]) begin
               m_serving[d] = -1;
               m_ticks[d]   = 0;
               m_esc[d]     = 1'b0;
            end else if (t) begin
               m_ticks[d] = (m_ticks[d] + 1 > ESC_P) ? ESC_P : m_ticks[d] + 1;
               if (m_ticks[d] == ESC_P) m_esc[d] = 1'b1;
            end
         end else if (m_in_gap[d]) begin
            if (t) begin
               m_gapcnt[d]++;
               if (m_gapcnt[d] == gap_of(d)) m_in_gap[d] = 1'b0;
            end
         end else if (old_pend != 4'b0000) begin
            for (int k = 1; k <= 4; k++) begin
               int room;
               room = (m_last[d] + k) % 4;
               if (!found && old_pend[room]) begin
                  found        = 1'b1;
                  m_serving[d] = room;
                  m_sel[d]     = room;
                  m_last[d]    = room;
                  m_ticks[d]   = 0;
                  m_esc[d]     = 1'b0;
               end
            end
         end
`ifdef ALARM_LATCH_EN
         m_pend[d] = (old_pend & ~clr) | (r & ~m_reqd[d]);
         m_reqd[d] = r;
`else
         m_pend[d] = r;
`endif
      end
   endtask

   task automatic check_all();
      for (int d = 0; d < 2; d++) begin
         logic [31:0] g;
         g = (m_serving[d] >= 0) ? (32'd1 << m_serving[d]) : 32'd0;
         chk($sformatf("d%0d.sel", d),      32'(sel_o[d]),    32'(m_sel[d]));
         chk($sformatf("d%0d.grant", d),    32'(grant_o[d]),  g);
         chk($sformatf("d%0d.active", d),   32'(active_o[d]), 32'(m_serving[d] >= 0));
         chk($sformatf("d%0d.escalate", d), 32'(esc_o[d]),    32'(m_esc[d]));
      end
   endtask

   task automatic step(input logic [3:0] r, input logic a, input logic t);
      req  = r;
      ack  = a;
      tick = t;
      @(posedge clk);
      model_edge(r, a, t);
      #1;
      check_all();
   endtask

   // Asynchronous reset asserted away from the clock edge; outputs must clear at once.
   task automatic do_reset();
      req  = 4'b0000;
      ack  = 1'b0;
      tick = 1'b0;
      #2 reset_n = 1'b0;
      #2;
      model_reset();
      check_all();
      @(posedge clk);
      #1 reset_n = 1'b1;
   endtask

   initial begin
      logic [3:0] r;
      logic       a;
      logic       t;

      reset_n = 1'b0;
      req     = 4'b0000;
      ack     = 1'b0;
      tick    = 1'b0;
      model_reset();
      #2;
      phase = "reset";
      check_all();
      @(posedge clk);
      @(posedge clk);
      #1 reset_n = 1'b1;

      // Single room, two-clock grant latency.
      phase = "latency";
      step(4'b0100, 1'b0, 1'b0);
      chk("grant_e0", 32'(grant_o[0]), 32'h0);
      step(4'b0100, 1'b0, 1'b0);
      chk("grant_e1",  32'(grant_o[0]),  32'h4);
      chk("sel_e1",    32'(sel_o[0]),    32'h2);
      chk("active_e1", 32'(active_o[0]), 32'h1);
      chk("esc_e1",    32'(esc_o[0]),    32'h0);
      step(4'b0100, 1'b1, 1'b0);
      step(4'b0000, 1'b0, 1'b1);
      step(4'b0000, 1'b0, 1'b1);
      step(4'b0000, 1'b0, 1'b0);

      // Round robin with no gap: rooms 0,1,2,3,0, each one clock after the ack.
      phase = "rr";
      do_reset();
      step(4'b1111, 1'b0, 1'b0);
      step(4'b1111, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) begin
         chk($sformatf("nogap.grant%0d", i), 32'(grant_o[1]), 32'd1 << (i % 4));
         step(4'b1111, 1'b1, 1'b0);
         chk($sformatf("nogap.drop%0d", i), 32'(grant_o[1]), 32'h0);
         step(4'b1111, 1'b0, 1'b0);
      end

      // Escalation after 8 unacked ticks, cleared by ack.
      phase = "esc";
      do_reset();
      step(4'b0010, 1'b0, 1'b0);
      step(4'b0010, 1'b0, 1'b0);
      for (int k = 1; k <= 8; k++) begin
         step(4'b0010, 1'b0, 1'b1);
         chk($sformatf("esc_tick%0d", k), 32'(esc_o[0]), 32'(k == 8));
      end
      step(4'b0010, 1'b1, 1'b0);
      chk("esc_after_ack",    32'(esc_o[0]),    32'h0);
      chk("grant_after_ack",  32'(grant_o[0]),  32'h0);
      chk("active_after_ack", 32'(active_o[0]), 32'h0);
      step(4'b0000, 1'b0, 1'b1);
      step(4'b0000, 1'b0, 1'b1);

      // Ack and tick together at count 7: ack wins.
      phase = "acktick";
      do_reset();
      step(4'b0010, 1'b0, 1'b0);
      step(4'b0010, 1'b0, 1'b0);
      for (int k = 1; k <= 7; k++) step(4'b0010, 1'b0, 1'b1);
      step(4'b0010, 1'b1, 1'b1);
      chk("esc_acktick",   32'(esc_o[0]),   32'h0);
      chk("grant_acktick", 32'(grant_o[0]), 32'h0);
      step(4'b0010, 1'b0, 1'b0);
      chk("gap_holds", 32'(grant_o[0]), 32'h0);
      step(4'b0000, 1'b0, 1'b1);
      step(4'b0000, 1'b0, 1'b1);
      step(4'b0000, 1'b0, 1'b1);

      // Brief request on room 3 while room 0 is served.
      phase = "latch";
      do_reset();
      step(4'b0001, 1'b0, 1'b0);
      step(4'b0001, 1'b0, 1'b0);
      step(4'b1001, 1'b0, 1'b0);
      step(4'b0001, 1'b0, 1'b0);
      step(4'b0000, 1'b1, 1'b0);
      step(4'b0000, 1'b0, 1'b1);
      step(4'b0000, 1'b0, 1'b1);
      step(4'b0000, 1'b0, 1'b0);
`ifdef ALARM_LATCH_EN
      chk("room3_latched", 32'(grant_o[0]), 32'h8);
`else
      chk("room3_dropped", 32'(grant_o[0]), 32'h0);
`endif
      step(4'b0000, 1'b0, 1'b0);

      // Reset in the middle of SERVE with two rooms pending.
      phase = "midreset";
      do_reset();
      step(4'b1010, 1'b0, 1'b0);
      step(4'b1010, 1'b0, 1'b0);
      chk("serving_before", 32'(active_o[0]), 32'h1);
      do_reset();
      step(4'b0000, 1'b0, 1'b0);
      step(4'b0000, 1'b0, 1'b0);
      chk("idle_after_rst", 32'(grant_o[0]), 32'h0);
      chk("inactive_after", 32'(active_o[1]), 32'h0);

      // Random traffic against the model.
      phase = "random";
      do_reset();
      r = 4'b0000;
      for (int n = 0; n < 400; n++) begin
         if ($urandom_range(0, 7) == 0) r = 4'($urandom_range(0, 15));
         a = ($urandom_range(0, 3) == 0);
         t = ($urandom_range(0, 2) == 0);
         step(r, a, t);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/alarm_arbiter_4ch.md
# alarm_arbiter_4ch

Round-robin scheduler that shares the 4-to-1 N-bit alarm-code multiplexer among four room alarm sources. It drives the mux select and a one-hot grant, holds each granted alarm until a nurse acknowledge, escalates unacknowledged alarms after a tick timeout, and enforces a blank gap between consecutive alarms. It sits between the synchronized room request inputs and the display/annunciator datapath fed by the mux.

## Interface
- `ESC_TICKS`, default 8: ticks in SERVE without ack before `escalate` asserts; must be ≥1.
- `GAP_TICKS`, default 2: ticks spent in GAP after an ack; 0 returns to IDLE on the next clock.
- `clk` input 1: single system clock, rising edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `req` input 4: room alarm requests, synchronous to `clk`, bit i = room i.
- `ack` input 1: single-cycle acknowledge pulse, synchronous.
- `tick` input 1: single-cycle time-base strobe (e.g. 1 Hz).
- `sel` output 2: mux select, the index of the granted/last-granted room.
- `grant` output 4: one-hot grant, all zero outside SERVE.
- `active` output 1: high in SERVE.
- `escalate` output 1: high in SERVE once the escalation count is reached.

## Operation
- `pending` register (4 bits) is the arbitration source; its update rule is set by the build macro (see Configuration).
- States: IDLE, SERVE, GAP.
- IDLE: if `pending` ≠ 0, pick the first set bit searching from `last+1` mod 4 upward with wrap; register `sel` to it, `grant` = one-hot(`sel`), `last` = `sel`, esc count = 0, go SERVE. Otherwise stay.
- SERVE:
  - `ack`: clear `pending[sel]`, clear esc count and `escalate`, drop `grant`/`active`, go GAP (or IDLE if `GAP_TICKS`=0).
  - `pending[sel]` = 0 without ack (non-latch build only): drop grant, go IDLE, no gap.
  - `tick` without ack: esc count +1, saturating at `ESC_TICKS`; `escalate` asserts on the edge where the count reaches `ESC_TICKS` and stays high until SERVE exits.
- GAP: count `tick` pulses; on the `GAP_TICKS`-th tick go IDLE. `ack` is ignored. `sel` holds its value.
- `ack` in IDLE or GAP has no effect.
- Counter widths are `$clog2(param+1)`. Ticks never wrap.
- Reset values: `sel`=0, `grant`=0, `active`=0, `escalate`=0, `pending`=0, `last`=3 so the first search starts at room 0. State = IDLE, all counters 0.
- Reset asserted mid-SERVE returns to IDLE immediately and discards all pending alarms.

## Timing
- `pending` is registered, so `req` sampled high at edge E0 gives `pending` high after E0, and `grant`/`active`/`sel` valid after E1. Grant latency from IDLE is 2 clocks.
- Acked alarm: `grant` drops on the edge that samples `ack`. With `GAP_TICKS`=0 the next grant appears one edge later.
- Simultaneous `ack` and `tick` in SERVE: ack wins, no escalation.
- Simultaneous set and clear of the same `pending` bit: set wins.
- All outputs are registered; none is combinational from inputs.

## Configuration
- Macro `ALARM_LATCH_EN`.
- Defined:
  - `pending[i]` is set on a rising edge of `req[i]`, detected with a registered `req_d`.
  - It is cleared only by ack while that room is served, so brief alarms are never lost.
  - A held-high request does not re-trigger after ack.
- Undefined:
  - `pending` = `req` registered each clock.
  - A dropped request withdraws the alarm, including mid-SERVE, per the SERVE rule above.

## Structure
- Shared package `alarm_pkg` holds:
  - state encodings `ST_IDLE`=2'd0, `ST_SERVE`=2'd1, `ST_GAP`=2'd2;
  - the room count constant `NUM_ROOMS`=4;
  - the select width 2.
- One combinational sub-module, `rr_pick4`. Inputs: `pending[3:0]`, `last[1:0]`. Outputs: `idx[1:0]`, `any`.

## Test plan
- Reset then `req`=4'b0100 held: `grant`=4'b0100, `sel`=2, `active`=1 exactly 2 clocks after first sample; `escalate`=0.
- `req`=4'b1111 held, ack each grant, `GAP_TICKS`=0: grant order is rooms 0,1,2,3,0, each grant one clock after its predecessor's ack.
- Room 1 served, 8 ticks without ack: `escalate` rises on the 8th tick edge. Ack then drops `escalate`, `grant`, and `active` on the same edge.
- `ack` and `tick` on the same cycle at esc count 7: no escalation; state is GAP and `grant`=0.
- Latch build: `req[3]` pulsed for 1 clock while room 0 is served. After room 0's ack and 2 gap ticks, room 3 is granted. Non-latch build: room 3 is never granted.
- `reset_n` low mid-SERVE with pending 4'b1010: all outputs return to 0 immediately. After release with `req`=0, state remains IDLE.
